// File: rtl/spi_deser_pkg.sv
// Shared FSM state type and counter-width helper for the SPI deserializer.
// SPI_DESER_PARITY_EN adds the PARITY state.
package spi_deser_pkg;

`ifdef SPI_DESER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  // Bit-counter width; never below one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/spi_deser_shreg.sv
// Serial-in shift register, MSB- or LSB-first, with clear.
// data_next exposes the word including the bit being sampled this edge.
module spi_deser_shreg #(
  parameter int WIDTH     = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next
);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      always_comb data_next = {data[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      always_comb data_next = {bit_in, data[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
    end else if (shift) begin
      data <= data_next;
    end
  end

endmodule

// File: rtl/spi_deserializer.sv
// Serial-to-parallel deserializer with valid/ready output and overrun flag.
// Define SPI_DESER_PARITY_EN to sample a trailing even-parity bit per word.
module spi_deserializer
  import spi_deser_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             sh_shift, sh_clear, word_done;
  logic [WIDTH-1:0] sh_data, sh_next, word_data;
`ifdef SPI_DESER_PARITY_EN
  logic             word_perr;
`endif

  spi_deser_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (sh_clear),
    .shift    (sh_shift),
    .bit_in   (serial_in),
    .data     (sh_data),
    .data_next(sh_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sh_shift   = 1'b0;
    sh_clear   = 1'b0;
    word_done  = 1'b0;
    word_data  = sh_next;
`ifdef SPI_DESER_PARITY_EN
    word_perr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          sh_shift   = 1'b1;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!enable) begin
          sh_clear   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          sh_shift = 1'b1;
          if (cnt == LAST) begin
            cnt_next = '0;
`ifdef SPI_DESER_PARITY_EN
            state_next = PARITY;
`else
            word_done  = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
`ifdef SPI_DESER_PARITY_EN
      PARITY: begin
        cnt_next   = '0;
        state_next = IDLE;
        if (!enable) begin
          sh_clear = 1'b1;
        end else begin
          // Data bits are complete in the register; this edge carries parity.
          word_done = 1'b1;
          word_data = sh_data;
          word_perr = ^{sh_data, serial_in};
        end
      end
`endif
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // A completing word is taken only if the slot is empty or draining this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done && (!out_valid || out_ready)) begin
        out_data  <= word_data;
        out_valid <= 1'b1;
      end else if (word_done) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (word_done && (!out_valid || out_ready)) begin
      parity_err <= word_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed self-checking bench for spi_deserializer (WIDTH=10, MSB- and LSB-first).
// Parity cases run when SPI_DESER_PARITY_EN is defined.
module tb_spi_deserializer;

  logic       clk = 1'b0;
  logic       rst, enable, serial_in, out_ready;
  logic [9:0] m_data, l_data;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  spi_deserializer #(.WIDTH(10), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overrun(m_ovr), .parity_err(m_perr)
  );

  spi_deserializer #(.WIDTH(10), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overrun(l_ovr), .parity_err(l_perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Everything except the bit that completes the word, first bit = w[9].
  task automatic send_head(input logic [9:0] w);
`ifdef SPI_DESER_PARITY_EN
    for (int i = 9; i >= 0; i--) begin
`else
    for (int i = 9; i >= 1; i--) begin
`endif
      enable = 1'b1; serial_in = w[i]; tick();
    end
  endtask

  task automatic send_tail(input logic [9:0] w);
    enable = 1'b1;
`ifdef SPI_DESER_PARITY_EN
    serial_in = ^w;
`else
    serial_in = w[0];
`endif
    tick();
  endtask

  task automatic send_word(input logic [9:0] w);
    send_head(w);
    send_tail(w);
  endtask

  task automatic idle();
    enable = 1'b0; serial_in = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
    tick(); tick();
    check("rst_data", 32'(m_data), 32'h0);
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_ovr", 32'(m_ovr | l_ovr), 32'h0);
    check("rst_perr", 32'(m_perr | l_perr), 32'h0);
    rst = 1'b0; enable = 1'b0; serial_in = 1'b0;
    tick();

    // Basic stream, both bit orders.
    send_word(10'b1011001110);
    check("msb_valid", 32'(m_valid), 32'h1);
    check("msb_data", 32'(m_data), 32'h2CE);
    check("lsb_data", 32'(l_data), 32'h1CD);
    check("lsb_valid", 32'(l_valid), 32'h1);
    idle();
    check("msb_valid_clr", 32'(m_valid), 32'h0);

    // Overrun: second back-to-back word dropped while stalled.
    out_ready = 1'b0;
    send_word(10'h3FF);
    check("ovr_first_data", 32'(m_data), 32'h3FF);
    check("ovr_none_yet", 32'(m_ovr), 32'h0);
    send_word(10'h001);
    check("ovr_pulse", 32'(m_ovr), 32'h1);
    check("ovr_held", 32'(m_data), 32'h3FF);
    idle();
    check("ovr_one_cycle", 32'(m_ovr), 32'h0);
    check("ovr_still_held", 32'(m_data), 32'h3FF);
    check("ovr_still_valid", 32'(m_valid), 32'h1);
    out_ready = 1'b1;
    idle();
    check("ovr_drain", 32'(m_valid), 32'h0);

    // New word completing on the same edge the held word is accepted.
    out_ready = 1'b0;
    send_word(10'h0F0);
    check("swap_first", 32'(m_data), 32'h0F0);
    send_head(10'h30F);
    out_ready = 1'b1;
    send_tail(10'h30F);
    check("swap_data", 32'(m_data), 32'h30F);
    check("swap_valid", 32'(m_valid), 32'h1);
    check("swap_no_ovr", 32'(m_ovr), 32'h0);
    idle();
    check("swap_drain", 32'(m_valid), 32'h0);

    // Abort after 6 bits, then a full word.
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; serial_in = 1'b1; tick();
    end
    idle();
    check("abort_no_valid", 32'(m_valid), 32'h0);
    send_word(10'h155);
    check("abort_data", 32'(m_data), 32'h155);
    check("abort_lsb_data", 32'(l_data), 32'h2AA);
    idle();

    // Reset mid-word while a word is held.
    out_ready = 1'b0;
    send_word(10'h155);
    check("pre_rst_valid", 32'(m_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; serial_in = 1'b1; tick();
    end
    rst = 1'b1; enable = 1'b1; serial_in = 1'b1;
    tick();
    check("mid_rst_data", 32'(m_data), 32'h0);
    check("mid_rst_valid", 32'(m_valid), 32'h0);
    check("mid_rst_ovr", 32'(m_ovr), 32'h0);
    check("mid_rst_perr", 32'(m_perr), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    send_word(10'h2AA);
    check("post_rst_data", 32'(m_data), 32'h2AA);
    check("post_rst_valid", 32'(m_valid), 32'h1);
    idle();

`ifdef SPI_DESER_PARITY_EN
    send_head(10'h007);
    enable = 1'b1; serial_in = 1'b0; tick();
    check("par_bad_err", 32'(m_perr), 32'h1);
    check("par_bad_data", 32'(m_data), 32'h007);
    idle();
    send_head(10'h007);
    enable = 1'b1; serial_in = 1'b1; tick();
    check("par_good_err", 32'(m_perr), 32'h0);
    check("par_good_valid", 32'(m_valid), 32'h1);
    idle();
`else
    send_word(10'h007);
    check("nopar_data", 32'(m_data), 32'h007);
    check("nopar_err", 32'(m_perr), 32'h0);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_deserializer.md
SPI_DESERIALIZER -- requirements
Module: spi_deserializer

Interface
REQ-001 Parameter WIDTH, default 10, data bits per word (2..32).
REQ-002 Parameter MSB_FIRST, default 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  frame enable; high = bit on serial_in sampled this edge; low = abort any partial word.
REQ-006 serial_in  input  1  serial data bit.
REQ-007 out_data  output  WIDTH  assembled word, stable while out_valid=1.
REQ-008 out_valid  output  1  word available.
REQ-009 out_ready  input  1  consumer accepts word when out_valid & out_ready.
REQ-010 overrun  output  1  one-cycle pulse: completed word dropped.
REQ-011 parity_err  output  1  parity status of held word (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-013 IDLE: enable=1 samples bit 0 and moves to SHIFT (WIDTH>=2); enable=0 stays IDLE.
REQ-014 SHIFT: each edge with enable=1 samples one bit and increments a $clog2(WIDTH)-bit counter; after bit WIDTH-1 go to PARITY (parity) or IDLE (no parity).
REQ-015 enable=0 in SHIFT or PARITY SHALL discard the partial word, clear the counter, return to IDLE, and leave out_data/out_valid untouched.
REQ-016 A word SHALL complete on the edge sampling its final bit (last data bit, or parity bit); out_valid SHALL be 1 the following cycle (latency 1 after final sample).
REQ-017 Back-to-back words SHALL be supported: the bit sampled on the edge after completion is bit 0 of the next word, no idle cycle required.
REQ-018 out_valid SHALL clear on the edge where out_valid & out_ready, unless a new word completes on that same edge, in which case the new word loads and out_valid stays 1.
REQ-019 If a word completes while out_valid=1 and out_ready=0: held word retained, new word dropped, overrun=1 for exactly the next cycle.
REQ-020 out_data SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-021 rst=1 at an edge SHALL force state IDLE, counter 0, shift register 0, out_data 0, out_valid 0, overrun 0, parity_err 0, regardless of enable or any frame in progress.
REQ-022 The first bit SHALL be sampled no earlier than the first edge with rst=0.

Configuration
REQ-023 Macro SPI_DESER_PARITY_EN defined: one extra bit after the WIDTH data bits is sampled in state PARITY; even parity over data+parity bit; parity_err=1 when the count of ones is odd, loaded and held alongside out_data; word delivered regardless.
REQ-024 Macro SPI_DESER_PARITY_EN undefined: no PARITY state, words are WIDTH bits, parity_err tied 0.

Structure
REQ-025 Package spi_deser_pkg SHALL hold the FSM state enum and the counter-width helper constant/function.
REQ-026 One sub-module spi_deser_shreg (WIDTH, MSB_FIRST shift register with load/clear) is natural; the FSM, handshake and overrun logic stay in spi_deserializer.

Verification
REQ-027 WIDTH=10, MSB_FIRST=1, out_ready=1, stream 10'b1011001110 -> out_data=10'h2CE, out_valid=1 one cycle after 10th sample, then 0.
REQ-028 MSB_FIRST=0, same stream -> out_data=10'h1CD.
REQ-029 Two back-to-back words 10'h3FF then 10'h001, out_ready=0 throughout -> out_data holds 10'h3FF, overrun pulses once, second word lost; then out_ready=1 for one cycle -> out_valid clears.
REQ-030 enable dropped after 6 bits, then a full word 10'h155 -> out_data=10'h155; partial bits absent.
REQ-031 rst asserted after bit 4 of a word -> next cycle all outputs 0, state IDLE; subsequent word 10'h2AA received correctly.
REQ-032 With SPI_DESER_PARITY_EN, word 10'h007 plus parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
